// File: rtl/bsg_mul_iterative_multimode_if.sv
// Handshake and operand bundle for the iterative multimode multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface bsg_mul_iterative_multimode_if #(parameter int width_p = 32);
  logic                   ready_o;
  logic                   v_i;
  logic [width_p-1:0]     opA_i;
  logic [width_p-1:0]     opB_i;
  logic                   opA_signed_i;
  logic                   opB_signed_i;
  logic [2*width_p-1:0]   result_o;
  logic                   v_o;
  logic                   yumi_i;

  modport master (
    input  ready_o, result_o, v_o,
    output v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, yumi_i
  );

  modport slave (
    output ready_o, result_o, v_o,
    input  v_i, opA_i, opB_i, opA_signed_i, opB_signed_i, yumi_i
  );
endinterface

// File: rtl/bsg_mul_iterative_multimode.sv
// Iterative multiplier: stride_p multiplier bits per cycle, any signedness mix,
// optional early exit once the remaining multiplier bits are pure sign fill.
module bsg_mul_iterative_multimode #(
  parameter int width_p     = 32,
  parameter int stride_p    = 8,
  parameter int early_out_p = 0
) (
  input logic                            clk_i,
  input logic                            reset_i,
  bsg_mul_iterative_multimode_if.slave   mul_if
);

  localparam int iter_lp      = width_p / stride_p;
  localparam int ctr_width_lp = (iter_lp > 1) ? $clog2(iter_lp) : 1;
  localparam bit early_lp     = (early_out_p != 0);

  typedef enum logic [1:0] {eIdle, eCal, eCPA, eDone} state_e;

  state_e                  state_r, state_n;
  logic [2*width_p-1:0]    a_shift_r;
  logic [width_p-1:0]      b_r;
  logic                    b_fill_r;
  logic [2*width_p-1:0]    acc_r;
  logic [ctr_width_lp-1:0] cnt_r;
  logic [2*width_p-1:0]    result_r;

  logic [stride_p-1:0]     digit;
  logic [2*width_p-1:0]    partial;
  logic [width_p-1:0]      fill_mask;
  logic [width_p-1:0]      b_next;
  logic                    rest_fill;
  logic                    last_iter;
  logic                    cal_done;
  logic [2*width_p-1:0]    correction;

  // Every chunk is an unsigned digit; a negative signed multiplier is the
  // unsigned value minus 2^k, so eCPA subtracts the multiplicand shifted to
  // the first unconsumed bit whenever the remaining bits are all ones.
  always_comb begin
    digit      = b_r[stride_p-1:0];
    partial    = a_shift_r * {{(2*width_p-stride_p){1'b0}}, digit};
    fill_mask  = b_fill_r ? ~({width_p{1'b1}} >> stride_p) : '0;
    b_next     = (b_r >> stride_p) | fill_mask;
    rest_fill  = (b_next == {width_p{b_fill_r}});
    last_iter  = (cnt_r == ctr_width_lp'(iter_lp - 1));
    cal_done   = last_iter | (early_lp & rest_fill);
    correction = b_fill_r ? a_shift_r : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eIdle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      eIdle:   if (mul_if.v_i)    state_n = eCal;
      eCal:    if (cal_done)      state_n = eCPA;
      eCPA:                       state_n = eDone;
      eDone:   if (mul_if.yumi_i) state_n = eIdle;
      default:                    state_n = eIdle;
    endcase
  end

  always_comb begin
    mul_if.ready_o  = (state_r == eIdle);
    mul_if.v_o      = (state_r == eDone);
    mul_if.result_o = result_r;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_shift_r <= '0;
      b_r       <= '0;
      b_fill_r  <= 1'b0;
      acc_r     <= '0;
      cnt_r     <= '0;
      result_r  <= '0;
    end else begin
      unique case (state_r)
        eIdle: begin
          if (mul_if.v_i) begin
            a_shift_r <= {{width_p{mul_if.opA_signed_i & mul_if.opA_i[width_p-1]}}, mul_if.opA_i};
            b_r       <= mul_if.opB_i;
            b_fill_r  <= mul_if.opB_signed_i & mul_if.opB_i[width_p-1];
            acc_r     <= '0;
            cnt_r     <= '0;
          end
        end
        eCal: begin
          acc_r     <= acc_r + partial;
          a_shift_r <= a_shift_r << stride_p;
          b_r       <= b_next;
          cnt_r     <= cnt_r + ctr_width_lp'(1);
        end
        eCPA: begin
          result_r <= acc_r - correction;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
